// File: rtl/memory_io_arbiter.sv
// memory_io_arbiter: round-robin sharing of the memory_io port between CPU (A) and DMA (B),
// with a response-tag pipeline routing read data back. Optional bus lock: IO_ARB_LOCK_EN.
module memory_io_arbiter #(
   parameter int READ_LATENCY = 2
) (
   input  logic        main_clk,
   input  logic        main_rst_n,
   input  logic        a_req,
   input  logic [31:0] a_addr,
   input  logic [15:0] a_wdata,
   input  logic [1:0]  a_ctrl,
`ifdef IO_ARB_LOCK_EN
   input  logic        a_lock,
`endif
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [15:0] a_rdata,
   input  logic        b_req,
   input  logic [31:0] b_addr,
   input  logic [15:0] b_wdata,
   input  logic [1:0]  b_ctrl,
`ifdef IO_ARB_LOCK_EN
   input  logic        b_lock,
`endif
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [15:0] b_rdata,
   output logic [31:0] address_io,
   output logic [15:0] data_in_io,
   output logic [1:0]  control_io,
   input  logic [15:0] data_out_io,
   output logic        busy
);

   logic        a_pick;
   logic        b_pick;
   logic        a_allow;
   logic        b_allow;
   logic        any_gnt;
   logic        gnt_is_read;
   logic [31:0] gnt_addr;
   logic [15:0] gnt_wdata;
   logic [1:0]  gnt_ctrl;

   // last_b_reg = 1 means B was granted most recently, so A wins the next tie
   logic        last_b_reg;
   logic        issue_reg;
   logic [31:0] address_reg;
   logic [15:0] data_in_reg;
   logic [1:0]  control_reg;

   logic        tag_valid_reg [READ_LATENCY+1];
   logic        tag_id_reg    [READ_LATENCY+1];
   logic        tag_any;

`ifdef IO_ARB_LOCK_EN
   typedef enum logic [1:0] {LOCK_NONE, LOCK_A, LOCK_B} lock_state_t;
   lock_state_t lock_state_reg;
   lock_state_t lock_state_next;
`endif

   always_comb begin
      a_pick  = 1'b0;
      b_pick  = 1'b0;
      a_allow = 1'b1;
      b_allow = 1'b1;
`ifdef IO_ARB_LOCK_EN
      lock_state_next = lock_state_reg;
      // owner keeps the bus while it requests or still asserts lock; idle with lock=0 releases
      case (lock_state_reg)
         LOCK_A: begin
            if (a_req || a_lock) b_allow = 1'b0;
            else                 lock_state_next = LOCK_NONE;
         end
         LOCK_B: begin
            if (b_req || b_lock) a_allow = 1'b0;
            else                 lock_state_next = LOCK_NONE;
         end
         default: ;
      endcase
`endif
      if (a_req && a_allow && b_req && b_allow) begin
         if (last_b_reg) a_pick = 1'b1;
         else            b_pick = 1'b1;
      end else if (a_req && a_allow) begin
         a_pick = 1'b1;
      end else if (b_req && b_allow) begin
         b_pick = 1'b1;
      end
      // grants are combinational, so hold them low while reset is asserted
      if (!main_rst_n) begin
         a_pick = 1'b0;
         b_pick = 1'b0;
      end
`ifdef IO_ARB_LOCK_EN
      if (a_pick)      lock_state_next = a_lock ? LOCK_A : LOCK_NONE;
      else if (b_pick) lock_state_next = b_lock ? LOCK_B : LOCK_NONE;
`endif
   end

`ifdef IO_ARB_LOCK_EN
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) lock_state_reg <= LOCK_NONE;
      else             lock_state_reg <= lock_state_next;
   end
`endif

   assign any_gnt     = a_pick | b_pick;
   assign gnt_addr    = a_pick ? a_addr  : b_addr;
   assign gnt_wdata   = a_pick ? a_wdata : b_wdata;
   assign gnt_ctrl    = a_pick ? a_ctrl  : b_ctrl;
   assign gnt_is_read = any_gnt & ~gnt_ctrl[1];

   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         last_b_reg  <= 1'b1;
         issue_reg   <= 1'b0;
         address_reg <= '0;
         data_in_reg <= '0;
         control_reg <= '0;
      end else begin
         issue_reg <= any_gnt;
         if (any_gnt) begin
            last_b_reg  <= b_pick;
            address_reg <= gnt_addr;
            data_in_reg <= gnt_wdata;
            control_reg <= gnt_ctrl;
         end else begin
            // idle cycle degenerates into a harmless read at the held address
            control_reg <= 2'b00;
         end
      end
   end

   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         tag_valid_reg[0] <= 1'b0;
         tag_id_reg[0]    <= 1'b0;
      end else begin
         tag_valid_reg[0] <= gnt_is_read;
         tag_id_reg[0]    <= b_pick;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi <= READ_LATENCY; gi++) begin : g_tag
         always_ff @(posedge main_clk or negedge main_rst_n) begin
            if (!main_rst_n) begin
               tag_valid_reg[gi] <= 1'b0;
               tag_id_reg[gi]    <= 1'b0;
            end else begin
               tag_valid_reg[gi] <= tag_valid_reg[gi-1];
               tag_id_reg[gi]    <= tag_id_reg[gi-1];
            end
         end
      end
   endgenerate

   always_comb begin
      tag_any = 1'b0;
      for (int i = 0; i <= READ_LATENCY; i++) tag_any = tag_any | tag_valid_reg[i];
   end

   // the last tag stage lines up with data_out_io for the access issued READ_LATENCY cycles ago
   assign a_rvalid = tag_valid_reg[READ_LATENCY] & ~tag_id_reg[READ_LATENCY];
   assign b_rvalid = tag_valid_reg[READ_LATENCY] &  tag_id_reg[READ_LATENCY];
   assign a_rdata  = a_rvalid ? data_out_io : 16'h0000;
   assign b_rdata  = b_rvalid ? data_out_io : 16'h0000;

   assign a_gnt      = a_pick;
   assign b_gnt      = b_pick;
   assign address_io = address_reg;
   assign data_in_io = data_in_reg;
   assign control_io = control_reg;
   assign busy       = any_gnt | issue_reg | tag_any;

endmodule

// File: tb/tb_memory_io_arbiter.sv
// Directed self-checking bench for memory_io_arbiter (READ_LATENCY=2); lock scenario when IO_ARB_LOCK_EN is set.
module tb_memory_io_arbiter;

   logic        main_clk = 1'b0;
   logic        main_rst_n = 1'b0;
   logic        a_req = 1'b0, b_req = 1'b0;
   logic [31:0] a_addr = '0, b_addr = '0;
   logic [15:0] a_wdata = '0, b_wdata = '0;
   logic [1:0]  a_ctrl = '0, b_ctrl = '0;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
   logic [15:0] a_rdata, b_rdata, data_in_io;
   logic [31:0] address_io;
   logic [1:0]  control_io;
   logic [15:0] data_out_io = '0;
`ifdef IO_ARB_LOCK_EN
   logic        a_lock = 1'b0, b_lock = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 main_clk = ~main_clk;

   memory_io_arbiter #(.READ_LATENCY(2)) dut (
      .main_clk(main_clk), .main_rst_n(main_rst_n),
      .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_ctrl(a_ctrl),
`ifdef IO_ARB_LOCK_EN
      .a_lock(a_lock),
`endif
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_ctrl(b_ctrl),
`ifdef IO_ARB_LOCK_EN
      .b_lock(b_lock),
`endif
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .address_io(address_io), .data_in_io(data_in_io), .control_io(control_io),
      .data_out_io(data_out_io), .busy(busy)
   );

   // each cycle: inputs driven 2 units after the rising edge, outputs sampled 1 unit later
   task automatic cyc();
      @(posedge main_clk);
      #2;
   endtask

   task automatic idle(input int n);
      a_req = 1'b0; b_req = 1'b0; data_out_io = '0;
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      #3;
      n_checks++; if (address_io !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h expected 0", address_io); end
      n_checks++; if (control_io !== 2'b00) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 00", control_io); end
      n_checks++; if ({busy, a_gnt, b_gnt, a_rvalid, b_rvalid} !== 5'b0) begin n_errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, a_gnt, b_gnt, a_rvalid, b_rvalid}); end
      cyc();
      main_rst_n = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_round_robin();
      logic        ea, eb, rva, rvb;
      logic [31:0] eaddr;
      int          j;
      for (int k = 0; k < 8; k++) begin
         cyc();
         a_req = (k < 4); b_req = (k < 4); a_ctrl = 2'b00; b_ctrl = 2'b00;
         a_addr = 32'h100 + 32'((k + 1) / 2);
         b_addr = 32'h200 + 32'(k / 2);
         data_out_io = 16'hA000 + 16'(k);
         #1;
         ea  = (k < 4) && (k % 2 == 0);
         eb  = (k < 4) && (k % 2 == 1);
         rva = (k >= 3) && (k <= 6) && ((k - 3) % 2 == 0);
         rvb = (k >= 3) && (k <= 6) && ((k - 3) % 2 == 1);
         $display("txn rr cycle %0d a_gnt=%b b_gnt=%b a_rvalid=%b b_rvalid=%b", k, a_gnt, b_gnt, a_rvalid, b_rvalid);
         n_checks++; if ({a_gnt, b_gnt} !== {ea, eb}) begin n_errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, {a_gnt, b_gnt}, {ea, eb}); end
         n_checks++; if ({a_rvalid, a_rdata} !== {rva, rva ? 16'hA000 + 16'(k) : 16'h0}) begin n_errors++; $display("FAIL rr_a_resp[%0d]: got %b/%h", k, a_rvalid, a_rdata); end
         n_checks++; if ({b_rvalid, b_rdata} !== {rvb, rvb ? 16'hA000 + 16'(k) : 16'h0}) begin n_errors++; $display("FAIL rr_b_resp[%0d]: got %b/%h", k, b_rvalid, b_rdata); end
         if (k >= 1 && k <= 4) begin
            j = k - 1;
            eaddr = (j % 2 == 0) ? 32'h100 + 32'((j + 1) / 2) : 32'h200 + 32'(j / 2);
            n_checks++; if (address_io !== eaddr) begin n_errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", k, address_io, eaddr); end
         end
      end
      idle(2);
   endtask

   task automatic test_single_read();
      cyc();
      a_req = 1'b1; a_addr = 32'h8100_0004; a_ctrl = 2'b00;
      #1;
      $display("txn single read A addr=%h", a_addr);
      n_checks++; if ({a_gnt, b_gnt, busy} !== 3'b101) begin n_errors++; $display("FAIL rd_gnt: got %b expected 101", {a_gnt, b_gnt, busy}); end
      cyc();
      a_req = 1'b0; #1;
      n_checks++; if (address_io !== 32'h8100_0004) begin n_errors++; $display("FAIL rd_addr: got %h expected 81000004", address_io); end
      n_checks++; if (control_io !== 2'b00) begin n_errors++; $display("FAIL rd_ctrl: got %b expected 00", control_io); end
      cyc(); #1;
      n_checks++; if (a_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_early: got %b expected 0", a_rvalid); end
      cyc();
      data_out_io = 16'h1234; #1;
      n_checks++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h1234}) begin n_errors++; $display("FAIL rd_resp: got %b/%h expected 1/1234", a_rvalid, a_rdata); end
      n_checks++; if ({b_rvalid, b_rdata} !== 17'h0) begin n_errors++; $display("FAIL rd_b_quiet: got %b/%h expected 0/0000", b_rvalid, b_rdata); end
      cyc();
      data_out_io = 16'h4321; #1;
      n_checks++; if ({a_rvalid, a_rdata, busy} !== 18'h0) begin n_errors++; $display("FAIL rd_done: got %b/%h busy=%b expected 0/0000 busy=0", a_rvalid, a_rdata, busy); end
      idle(1);
   endtask

   task automatic test_write();
      cyc();
      a_req = 1'b1; a_addr = 32'h8000_0003; a_ctrl = 2'b10; a_wdata = 16'h0001;
      #1;
      $display("txn write A addr=%h data=%h", a_addr, a_wdata);
      n_checks++; if (a_gnt !== 1'b1) begin n_errors++; $display("FAIL wr_gnt: got %b expected 1", a_gnt); end
      cyc();
      a_req = 1'b0; #1;
      n_checks++; if ({control_io, data_in_io, address_io} !== {2'b10, 16'h0001, 32'h8000_0003}) begin n_errors++; $display("FAIL wr_bus: got %b %h %h", control_io, data_in_io, address_io); end
      for (int k = 0; k < 4; k++) begin
         cyc();
         data_out_io = 16'hBEEF; #1;
         n_checks++; if (a_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr_no_rvalid[%0d]: got %b expected 0", k, a_rvalid); end
         if (k == 0) begin
            n_checks++; if ({control_io, address_io} !== {2'b00, 32'h8000_0003}) begin n_errors++; $display("FAIL wr_idle_hold: got %b %h expected 00 80000003", control_io, address_io); end
         end
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      cyc();
      b_req = 1'b1; b_addr = 32'h8180_0000; b_ctrl = 2'b00; #1;
      $display("txn b2b B read addr=%h", b_addr);
      n_checks++; if ({a_gnt, b_gnt} !== 2'b01) begin n_errors++; $display("FAIL b2b_gnt0: got %b expected 01", {a_gnt, b_gnt}); end
      cyc();
      b_addr = 32'h8180_0001; #1;
      $display("txn b2b B read addr=%h", b_addr);
      n_checks++; if (b_gnt !== 1'b1) begin n_errors++; $display("FAIL b2b_gnt1: got %b expected 1", b_gnt); end
      n_checks++; if (address_io !== 32'h8180_0000) begin n_errors++; $display("FAIL b2b_addr0: got %h expected 81800000", address_io); end
      cyc();
      b_req = 1'b0; #1;
      n_checks++; if (address_io !== 32'h8180_0001) begin n_errors++; $display("FAIL b2b_addr1: got %h expected 81800001", address_io); end
      cyc();
      data_out_io = 16'h5555; #1;
      n_checks++; if ({b_rvalid, b_rdata, a_rvalid} !== {1'b1, 16'h5555, 1'b0}) begin n_errors++; $display("FAIL b2b_resp0: got %b/%h a=%b", b_rvalid, b_rdata, a_rvalid); end
      cyc();
      data_out_io = 16'h6666; #1;
      n_checks++; if ({b_rvalid, b_rdata, a_rvalid} !== {1'b1, 16'h6666, 1'b0}) begin n_errors++; $display("FAIL b2b_resp1: got %b/%h a=%b", b_rvalid, b_rdata, a_rvalid); end
      cyc();
      data_out_io = 16'h7777; #1;
      n_checks++; if (b_rvalid !== 1'b0) begin n_errors++; $display("FAIL b2b_end: got %b expected 0", b_rvalid); end
      idle(1);
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp_seq [3];
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10;
      for (int k = 0; k < 3; k++) begin
         cyc();
         a_req = 1'b1; b_req = 1'b1; a_ctrl = 2'b00; b_ctrl = 2'b00;
         a_addr = 32'h300 + 32'(k); b_addr = 32'h400 + 32'(k); #1;
         n_checks++; if ({a_gnt, b_gnt} !== exp_seq[k]) begin n_errors++; $display("FAIL rst_seq[%0d]: got %b expected %b", k, {a_gnt, b_gnt}, exp_seq[k]); end
      end
      cyc();
      main_rst_n = 1'b0; data_out_io = 16'h9999; #1;
      $display("txn reset asserted with three reads in flight");
      n_checks++; if ({address_io, data_in_io, control_io} !== 50'h0) begin n_errors++; $display("FAIL rst_bus: got %h %h %b expected zeros", address_io, data_in_io, control_io); end
      n_checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, busy} !== 5'b0) begin n_errors++; $display("FAIL rst_flags: got %b expected 00000", {a_gnt, b_gnt, a_rvalid, b_rvalid, busy}); end
      cyc();
      main_rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         data_out_io = 16'h9999; #1;
         n_checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_errors++; $display("FAIL rst_no_rvalid[%0d]: got %b expected 00", k, {a_rvalid, b_rvalid}); end
      end
      cyc();
      a_req = 1'b1; b_req = 1'b1; a_ctrl = 2'b10; b_ctrl = 2'b10; #1;
      n_checks++; if ({a_gnt, b_gnt} !== 2'b10) begin n_errors++; $display("FAIL rst_first_gnt: got %b expected 10", {a_gnt, b_gnt}); end
      cyc();
      a_req = 1'b0; #1;
      n_checks++; if (b_gnt !== 1'b1) begin n_errors++; $display("FAIL rst_second_gnt: got %b expected 1", b_gnt); end
      idle(4);
   endtask

`ifdef IO_ARB_LOCK_EN
   task automatic test_lock();
      for (int k = 0; k < 5; k++) begin
         cyc();
         a_req = (k < 4); a_lock = (k < 3); a_ctrl = 2'b10; a_addr = 32'h500 + 32'(k);
         b_req = (k >= 1); b_lock = 1'b0; b_ctrl = 2'b10; b_addr = 32'h600;
         #1;
         $display("txn lock cycle %0d a_gnt=%b b_gnt=%b", k, a_gnt, b_gnt);
         n_checks++; if ({a_gnt, b_gnt} !== ((k < 4) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL lock_gnt[%0d]: got %b expected %b", k, {a_gnt, b_gnt}, (k < 4) ? 2'b10 : 2'b01); end
      end
      idle(2);
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single_read();
      test_write();
      test_back_to_back();
      test_reset_mid();
`ifdef IO_ARB_LOCK_EN
      test_lock();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
